// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: direct-mapped data-cache tag controller (16-byte lines) with miss FSM.
//   Tag RAM (1r1w, registered read) holds tags; valid/dirty bits live in flops here.
//   Ports: clk, rst (sync, active-high); req_valid/req_adr/req_we in, req_done/stall out;
//   tag_radr/tag_rdata read port; tag_wadr/tag_wdata/tag_wen write port;
//   wb_req/wb_adr/wb_ack writeback handshake; rf_req/rf_adr/rf_ack refill handshake.
//   Optional DCACHE_FLUSH_EN adds flush_req/flush_done: walk every line, write back
//   valid dirty lines, then invalidate all.
module dcache_tag_ctrl #(
  parameter int DRWIDTH = 9,
  localparam int TW = 24 - DRWIDTH,
  localparam int LINES = 2 ** DRWIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [27:0]        req_adr,
  input  logic               req_we,
  output logic               req_done,
  output logic               stall,
  output logic [DRWIDTH-1:0] tag_radr,
  input  logic [TW-1:0]      tag_rdata,
  output logic [DRWIDTH-1:0] tag_wadr,
  output logic [TW-1:0]      tag_wdata,
  output logic               tag_wen,
  output logic               wb_req,
  output logic [23:0]        wb_adr,
  input  logic               wb_ack,
  output logic               rf_req,
  output logic [23:0]        rf_adr,
  input  logic               rf_ack
`ifdef DCACHE_FLUSH_EN
  ,
  input  logic               flush_req,
  output logic               flush_done
`endif
);
  localparam logic [2:0] S_IDLE = 3'd0, S_LOOKUP = 3'd1, S_WBACK = 3'd2, S_REFILL = 3'd3, S_UPDATE = 3'd4;
`ifdef DCACHE_FLUSH_EN
  localparam logic [2:0] S_FL_RD = 3'd5, S_FL_CHK = 3'd6, S_FL_WB = 3'd7;
  logic [DRWIDTH-1:0] cnt;
  logic fl_dirty, fl_step;
`endif
  logic [2:0] state, nxt;
  logic [TW-1:0] tag_q, victim, req_tag;
  logic [DRWIDTH-1:0] idx_q, widx, req_idx;
  logic we_q, hit, unused_ok;
  logic [LINES-1:0] valid, dirty;
  assign req_tag = req_adr[27:DRWIDTH+4];
  assign req_idx = req_adr[DRWIDTH+3:4];
  assign unused_ok = ^req_adr[3:0];
  assign hit = valid[idx_q] && tag_rdata == tag_q;
  assign tag_wadr = idx_q;
  assign tag_wdata = tag_q;
  assign tag_wen = state == S_UPDATE;
  assign rf_req = state == S_REFILL;
  assign rf_adr = {tag_q, idx_q};
  // widx is the line index of the pending writeback (miss victim or flush line)
  assign wb_adr = {victim, widx};
  always_comb begin
    tag_radr = state == S_IDLE ? req_idx : idx_q;
    req_done = (state == S_LOOKUP && hit) || state == S_UPDATE;
    stall = state == S_IDLE ? req_valid : req_valid && !req_done;
    wb_req = state == S_WBACK;
    case (state)
      S_IDLE:   nxt = req_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: nxt = hit ? S_IDLE : (valid[idx_q] && dirty[idx_q]) ? S_WBACK : S_REFILL;
      S_WBACK:  nxt = wb_ack ? S_REFILL : S_WBACK;
      S_REFILL: nxt = rf_ack ? S_UPDATE : S_REFILL;
      default:  nxt = S_IDLE;
    endcase
`ifdef DCACHE_FLUSH_EN
    fl_dirty = valid[cnt] && dirty[cnt];
    fl_step = (state == S_FL_CHK && !fl_dirty) || (state == S_FL_WB && wb_ack);
    flush_done = fl_step && &cnt;
    if (state == S_FL_RD || state == S_FL_CHK) tag_radr = cnt;
    if (state >= S_FL_RD) stall = 1'b1;
    if (state == S_FL_WB) wb_req = 1'b1;
    if (state == S_IDLE && flush_req) nxt = S_FL_RD;
    if (state == S_FL_RD) nxt = S_FL_CHK;
    if (state == S_FL_CHK) nxt = fl_dirty ? S_FL_WB : flush_done ? S_IDLE : S_FL_RD;
    if (state == S_FL_WB) nxt = !wb_ack ? S_FL_WB : flush_done ? S_IDLE : S_FL_RD;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tag_q <= '0;
      idx_q <= '0;
      we_q <= 1'b0;
      victim <= '0;
      widx <= '0;
      valid <= '0;
      dirty <= '0;
`ifdef DCACHE_FLUSH_EN
      cnt <= '0;
`endif
    end else begin
      state <= nxt;
      if (state == S_IDLE && req_valid) begin
        tag_q <= req_tag;
        idx_q <= req_idx;
        we_q <= req_we;
      end
      if (state == S_LOOKUP && hit && we_q) dirty[idx_q] <= 1'b1;
      if (state == S_LOOKUP && !hit) begin
        victim <= tag_rdata;
        widx <= idx_q;
      end
      if (state == S_UPDATE) begin
        valid[idx_q] <= 1'b1;
        dirty[idx_q] <= we_q;
      end
`ifdef DCACHE_FLUSH_EN
      if (state == S_FL_CHK) begin
        victim <= tag_rdata;
        widx <= cnt;
      end
      // cnt wraps to 0 after the last line, ready for the next flush
      if (fl_step) begin
        valid[cnt] <= 1'b0;
        dirty[cnt] <= 1'b0;
        cnt <= cnt + 1'b1;
      end
`endif
    end
  end
endmodule
